tx_dco_sweep_ctrl: RTL

Autonomous DC-offset calibration sequencer for the TX frontend. It sweeps a 2-D grid of I/Q DC-offset values by issuing writes on the frontend's settings bus, waits for a settle time, and collects one power measurement per point. It tracks the minimum, then programs the winning offsets. It sits between the host settings bus and the frontend, forwarding host writes and arbitrating them against its own writes.

---
 rtl/tx_dco_sweep_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tx_dco_sweep_ctrl.sv
// tx_dco_sweep_ctrl: TX DC-offset calibration sequencer sweeping an I/Q grid for minimum power,
// forwarding host settings writes with priority over its own frontend writes.
module tx_dco_sweep_ctrl #(
   parameter logic [7:0] BASE    = 8'd0,
   parameter logic [7:0] FE_BASE = 8'd0
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        set_stb_i,
   input  logic [7:0]  set_addr_i,
   input  logic [31:0] set_data_i,
   input  logic        pwr_stb_i,
   input  logic [31:0] pwr_val_i,
   output logic        out_stb_o,
   output logic [7:0]  out_addr_o,
   output logic [31:0] out_data_o,
   output logic        busy_o,
   output logic        done_o,
   output logic [23:0] best_i_o,
   output logic [23:0] best_q_o,
   output logic [31:0] best_pwr_o
);
   typedef enum logic [3:0] {
      IDLE, WR_I, WR_Q, SETTLE, MEAS, NEXT, WR_BEST_I, WR_BEST_Q, FIN
   } state_t;
   state_t      state_q;
   logic [23:0] i_start_q, q_start_q, step_q, cur_i_q, cur_q_q;
   logic [7:0]  n_i_q, n_q_q, idx_i_q, idx_q_q;
   logic [15:0] settle_q, cnt_q;
   logic        out_stb_q, busy_q, done_q;
   logic [7:0]  out_addr_q;
   logic [31:0] out_data_q, best_pwr_q;
   logic [23:0] best_i_q, best_q_q;
   logic [7:0]  off, ni_m1, nq_m1, eng_addr;
   logic [23:0] eng_val, nxt_i_d, nxt_q_d;
   logic        cfg_we, go, abort, eng_req, issue, settle_done;
   always_comb begin
      off         = set_addr_i - BASE;
      cfg_we      = set_stb_i && off < 8'd6;
      go          = cfg_we && off == 8'd5 && set_data_i[0] && !set_data_i[1];
      abort       = cfg_we && off == 8'd5 && set_data_i[1];
      ni_m1       = (n_i_q == 8'd0) ? 8'd0 : n_i_q - 8'd1;
      nq_m1       = (n_q_q == 8'd0) ? 8'd0 : n_q_q - 8'd1;
      nxt_i_d     = cur_i_q + step_q;
      nxt_q_d     = cur_q_q + step_q;
      settle_done = {1'b0, cnt_q} + 17'd1 >= {1'b0, settle_q};
      eng_req     = state_q == WR_I || state_q == WR_Q || state_q == WR_BEST_I || state_q == WR_BEST_Q;
      // host writes always win the bus; the engine simply retries next cycle
      issue       = eng_req && !set_stb_i;
      eng_addr    = (state_q == WR_Q || state_q == WR_BEST_Q) ? FE_BASE + 8'd1 : FE_BASE;
      eng_val     = (state_q == WR_I) ? cur_i_q :
                    (state_q == WR_Q) ? cur_q_q :
                    (state_q == WR_BEST_I) ? best_i_q : best_q_q;
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= IDLE;
         i_start_q  <= '0;
         q_start_q  <= '0;
         step_q     <= '0;
         n_i_q      <= '0;
         n_q_q      <= '0;
         settle_q   <= '0;
         cur_i_q    <= '0;
         cur_q_q    <= '0;
         idx_i_q    <= '0;
         idx_q_q    <= '0;
         cnt_q      <= '0;
         out_stb_q  <= 1'b0;
         out_addr_q <= '0;
         out_data_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         best_i_q   <= '0;
         best_q_q   <= '0;
         best_pwr_q <= '0;
      end else begin
         out_stb_q <= set_stb_i || issue;
         if (set_stb_i) begin
            out_addr_q <= set_addr_i;
            out_data_q <= set_data_i;
         end else if (issue) begin
            out_addr_q <= eng_addr;
            out_data_q <= {{8{eng_val[23]}}, eng_val};
         end
         if (cfg_we && off == 8'd0) i_start_q <= set_data_i[23:0];
         if (cfg_we && off == 8'd1) q_start_q <= set_data_i[23:0];
         if (cfg_we && off == 8'd2) step_q <= set_data_i[23:0];
         if (cfg_we && off == 8'd3) begin
            n_i_q <= set_data_i[7:0];
            n_q_q <= set_data_i[15:8];
         end
         if (cfg_we && off == 8'd4) settle_q <= set_data_i[15:0];
         if (abort && state_q != IDLE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: if (go) begin
                  state_q    <= WR_I;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  best_pwr_q <= '1;
                  cur_i_q    <= i_start_q;
                  cur_q_q    <= q_start_q;
                  idx_i_q    <= '0;
                  idx_q_q    <= '0;
               end
               WR_I: if (issue) state_q <= WR_Q;
               WR_Q: if (issue) begin
                  state_q <= SETTLE;
                  cnt_q   <= '0;
               end
               SETTLE: if (settle_done) state_q <= MEAS;
                       else cnt_q <= cnt_q + 16'd1;
               MEAS: if (pwr_stb_i) begin
                  if (pwr_val_i < best_pwr_q) begin
                     best_pwr_q <= pwr_val_i;
                     best_i_q   <= cur_i_q;
                     best_q_q   <= cur_q_q;
                  end
                  state_q <= NEXT;
               end
               NEXT: if (idx_i_q < ni_m1) begin
                  cur_i_q <= nxt_i_d;
                  idx_i_q <= idx_i_q + 8'd1;
                  state_q <= WR_I;
               end else if (idx_q_q < nq_m1) begin
                  cur_i_q <= i_start_q;
                  idx_i_q <= '0;
                  cur_q_q <= nxt_q_d;
                  idx_q_q <= idx_q_q + 8'd1;
                  state_q <= WR_I;
               end else state_q <= WR_BEST_I;
               WR_BEST_I: if (issue) state_q <= WR_BEST_Q;
               WR_BEST_Q: if (issue) state_q <= FIN;
               FIN: begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end
   assign out_stb_o  = out_stb_q;
   assign out_addr_o = out_addr_q;
   assign out_data_o = out_data_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign best_i_o   = best_i_q;
   assign best_q_o   = best_q_q;
   assign best_pwr_o = best_pwr_q;
endmodule
